avalon_mm_test_master: RTL and testbench
========================================

// Module: avalon_mm_test_master
// PURPOSE
//  Self-checking Avalon-MM master: writes a known pattern into N_WORDS slave
//  locations, reads them back, compares, then raises done (and error on mismatch).
//  Sits between a bring-up controller and any Avalon-MM slave with waitrequest
//  and pipelined readdatavalid; used as a memory/interconnect smoke test.
// PARAMETERS
//  N_WORDS    4   number of locations exercised, addresses 0..N_WORDS-1 (1..16)
//  DATA_BASE  5   pattern: word at address a is (a + DATA_BASE) mod 16
// PORTS
//  clock          in   1  single clock, all logic on rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  waitrequest    in   1  slave stall; command accepted only when low
//  readdatavalid  in   1  readdata valid this cycle (response to an accepted read)
//  readdata       in   4  read data from slave
//  read           out  1  read command
//  write          out  1  write command
//  address        out  4  word address
//  writedata      out  4  write data
//  done           out  1  test complete, sticky until reset
//  error          out  1  at least one readback mismatch, sticky; meaningful when done=1
// BEHAVIOUR
//  - All outputs registered. reset_n=0 (async): read=write=0, address=0,
//    writedata=0, done=0, error=0, state=WR, index=0.
//  - Accept: rising edge where (read|write)=1 and waitrequest=0. Until accept,
//    read/write/address/writedata held stable regardless of waitrequest.
//  - Never read and write together. At most one read outstanding.
//  - States:
//    WR    : write=1, address=index, writedata=index+DATA_BASE. On accept:
//            write=0 next cycle; index==N_WORDS-1 -> index=0, RD; else index+1,
//            stay WR (write re-asserted after one idle cycle with write=0).
//    RD    : read=1, address=index. On accept: read=0, go RDW; address held.
//    RDW   : wait for readdatavalid (any number of cycles, waitrequest ignored).
//            On readdatavalid: if readdata != index+DATA_BASE set error.
//            index==N_WORDS-1 -> DONE; else index+1, RD.
//    DONE  : read=write=0, done=1 forever (until reset). Inputs ignored.
//  - First command (write to 0) appears in the first cycle after reset_n rises.
//  - waitrequest may be low for only one cycle; acceptance in that cycle must
//    not be missed. waitrequest low while idle (read=write=0) has no effect.
//  - readdatavalid outside RDW is ignored (no error, no state change).
//  - index width: 4 bits, arithmetic mod 16; pattern add mod 16 (e.g. 12+5=1).
//  - Reset mid-operation: immediate return to reset values; restart from address 0.
// TESTING
//  1. Slave of 4x4-bit regs, waitrequest low 1 cycle, 3 cycles after request,
//     readdatavalid 1 cycle after read accept -> writes a0..3=5,6,7,8, reads
//     5,6,7,8, done=1, error=0.
//  2. waitrequest held low always -> each write accepted in one cycle with one
//     idle cycle between; sequence completes, done=1, error=0.
//  3. Slave corrupts address 2 (returns 0) -> done=1, error=1; other reads pass.
//  4. Stall write to addr 1 for 10 cycles -> write/address=1/writedata=6 stable
//     all 10 cycles; exactly one write accepted.
//  5. Spurious readdatavalid during WR, and reset_n pulse mid-read -> no error;
//     after reset all outputs 0, then write to address 0 with data 5 restarts.

Source files
------------

// File: rtl/avalon_mm_test_master.sv
// avalon_mm_test_master: writes a known pattern into an Avalon-MM slave,
// reads it back and raises done, with error flagging any mismatch.
module avalon_mm_test_master #(
  parameter int N_WORDS   = 4,
  parameter int DATA_BASE = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       waitrequest,
  input  logic       readdatavalid,
  input  logic [3:0] readdata,
  output logic       read,
  output logic       write,
  output logic [3:0] address,
  output logic [3:0] writedata,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    WR,
    RD,
    RDW,
    DONE
  } state_t;

  localparam logic [3:0] BASE = 4'(DATA_BASE);
  localparam logic [3:0] LAST = 4'(N_WORDS - 1);

  state_t     state_q, state_d;
  logic [3:0] index_q, index_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       accept;
  logic [3:0] pattern;

  assign accept  = (read_q | write_q) & ~waitrequest;
  assign pattern = index_q + BASE;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
    unique case (state_q)
      WR: begin
        if (accept) begin
          write_d = 1'b0;
          if (index_q == LAST) begin
            index_d = '0;
            state_d = RD;
          end else begin
            index_d = index_q + 4'd1;
          end
        end else if (!write_q) begin
          write_d = 1'b1;
          addr_d  = index_q;
          wdata_d = pattern;
        end
      end
      RD: begin
        if (accept) begin
          read_d  = 1'b0;
          state_d = RDW;
        end else if (!read_q) begin
          read_d = 1'b1;
          addr_d = index_q;
        end
      end
      RDW: begin
        if (readdatavalid) begin
          if (readdata != pattern) error_d = 1'b1;
          if (index_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 4'd1;
            state_d = RD;
          end
        end
      end
      DONE: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = WR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WR;
      index_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign address   = addr_q;
  assign writedata = wdata_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_avalon_mm_test_master.sv
// tb_avalon_mm_test_master: scenario table driving a modelled slave,
// plus a reset-mid-read sequence.
module tb_avalon_mm_test_master;
  localparam int N    = 4;
  localparam int BASE = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       waitrequest = 1'b1;
  logic       readdatavalid = 1'b0;
  logic [3:0] readdata = '0;
  logic       read, write, done, error;
  logic [3:0] address, writedata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  avalon_mm_test_master #(.N_WORDS(N), .DATA_BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .read(read), .write(write),
    .address(address), .writedata(writedata),
    .done(done), .error(error)
  );

  // modes: 0 always ready, 1 ready 3 cycles after request,
  // 2 random, 3 stall write to addr 1 for 10 cycles, 4 random + spurious rdv
  typedef struct {
    int mode;
    int lat;
    int corrupt;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  int mode = 0, lat = 1, corrupt = -1;
  bit junk = 0;
  logic [3:0] mem[16];
  int pend = 0, pend_addr = 0, req_cnt = 0, stall1 = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_idx = 0;
  bit outstanding = 0, prev_req = 0, prev_acc = 0, prev_wr_acc = 0;
  logic prev_rd, prev_wr;
  logic [3:0] prev_addr, prev_wd;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    wr_cnt = 0;
    rd_cnt = 0;
    tx_idx = 0;
    stall1 = 0;
    for (int a = 0; a < 16; a++) mem[a] = 4'hx;
  endtask

  // accepted transaction k must be write k for k<N, else read k-N
  task automatic record_accept();
    if (tx_idx >= 2 * N) begin
      check(0, "extra_tx", tx_idx, 2 * N - 1);
    end else if (write) begin
      check(tx_idx < N, "tx_kind_w", tx_idx, N - 1);
      check(int'(address) == tx_idx, "wr_addr", address, tx_idx);
      check(int'(writedata) == (tx_idx + BASE) % 16, "wr_data",
            writedata, (tx_idx + BASE) % 16);
      mem[address] = writedata;
      wr_cnt++;
    end else begin
      check(tx_idx >= N, "tx_kind_r", tx_idx, N);
      check(int'(address) == tx_idx - N, "rd_addr", address, tx_idx - N);
      pend = (lat > 0) ? lat : int'($urandom_range(1, 3));
      pend_addr = int'(address);
      outstanding = 1;
      rd_cnt++;
    end
    tx_idx++;
  endtask

  initial begin : slave
    bit acc;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend = 0;
        readdatavalid = 0;
        waitrequest = 1;
        prev_req = 0;
        prev_acc = 0;
        prev_wr_acc = 0;
        outstanding = 0;
        req_cnt = 0;
      end else begin
        if (read && write) check(0, "rw_excl", 1, 0);
        if (prev_req && !prev_acc)
          check(read == prev_rd && write == prev_wr &&
                address == prev_addr && writedata == prev_wd,
                "cmd_stable", {read, write, address, writedata},
                {prev_rd, prev_wr, prev_addr, prev_wd});
        if (prev_wr_acc) check(write == 1'b0, "wr_idle_gap", write, 0);
        if (outstanding) check(read == 1'b0, "one_outstanding", read, 0);
        readdatavalid = 0;
        readdata = 4'($urandom_range(0, 15));
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            readdatavalid = 1;
            readdata = (pend_addr == corrupt) ? 4'd0 : mem[pend_addr];
            outstanding = 0;
          end
        end else if ((mode == 4 && wr_cnt < N) || junk) begin
          readdatavalid = 1'($urandom_range(0, 1));
        end
        acc = 0;
        if (read || write) begin
          if (!prev_req || prev_acc) req_cnt = 0;
          else req_cnt++;
          case (mode)
            0: waitrequest = 0;
            1: waitrequest = (req_cnt != 3);
            3: begin
              if (write && address == 4'd1) begin
                waitrequest = (req_cnt < 10);
                if (waitrequest && writedata == 4'd6) stall1++;
              end else begin
                waitrequest = 0;
              end
            end
            default: waitrequest = ($urandom_range(0, 2) != 0);
          endcase
          acc = !waitrequest;
          if (acc) record_accept();
        end else begin
          waitrequest = 1'($urandom_range(0, 1));
        end
        prev_req = read || write;
        prev_acc = acc;
        prev_wr_acc = acc && write;
        prev_rd = read;
        prev_wr = write;
        prev_addr = address;
        prev_wd = writedata;
      end
    end
  end

  task automatic start_reset();
    reset_n = 0;
    clear_model();
    #1;
    check({read, write, address, writedata, done, error} == 12'd0,
          "reset_vals", {read, write, address, writedata, done, error}, 0);
  endtask

  task automatic release_and_first();
    @(negedge clock);
    #2 reset_n = 1;
    @(negedge clock);
    #1;
    check(write && !read && address == 4'd0 && writedata == 4'd5,
          "first_cmd", {read, write, address, writedata}, 9'b0_1_0000_0101);
  endtask

  task automatic run_to_done(input bit exp_err);
    int cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    #1;
    check(done, "done", done, 1);
    check(error == exp_err, "error", error, exp_err);
    check(wr_cnt == N, "wr_count", wr_cnt, N);
    check(rd_cnt == N, "rd_count", rd_cnt, N);
  endtask

  initial begin : main
    bit bad;
    vecs[0] = '{1, 1, -1, 1'b0};
    vecs[1] = '{0, 1, -1, 1'b0};
    vecs[2] = '{1, 1,  2, 1'b1};
    vecs[3] = '{3, 1, -1, 1'b0};
    vecs[4] = '{2, 0, -1, 1'b0};
    vecs[5] = '{4, 0, -1, 1'b0};
    vecs[6] = '{2, 0,  3, 1'b1};
    clear_model();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      #2;
      mode = vecs[i].mode;
      lat = vecs[i].lat;
      corrupt = vecs[i].corrupt;
      junk = 0;
      start_reset();
      @(negedge clock);
      release_and_first();
      run_to_done(vecs[i].exp_err);
      if (vecs[i].mode == 3) check(stall1 == 10, "stall_addr1", stall1, 10);
      junk = 1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        #1;
        if (read || write || !done || error != vecs[i].exp_err) bad = 1;
      end
      check(!bad, "done_sticky", bad, 0);
      junk = 0;
    end

    // reset pulse while a read is outstanding
    @(negedge clock);
    #2;
    mode = 0;
    lat = 3;
    corrupt = -1;
    start_reset();
    release_and_first();
    for (int c = 0; c < 200 && rd_cnt < 1; c++) @(negedge clock);
    check(rd_cnt == 1, "reached_read", rd_cnt, 1);
    #3;
    start_reset();
    release_and_first();
    run_to_done(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
